// File: rtl/udp_payload_packer.sv
// Packs 4-byte words drained from an FWFT return FIFO into framed UDP payload
// packets (MAGIC, seq, word count, XOR checksum, then payload) on an AXI-Stream byte port.
module udp_payload_packer #(
    parameter int         MAX_WORDS    = 16,
    parameter int         IDLE_TIMEOUT = 1000,
    parameter logic [7:0] MAGIC        = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] s_fifo_dout,
    input  logic       s_fifo_empty,
    output logic       s_fifo_rd_en,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    output logic       m_axis_tlast,
    input  logic       m_axis_tready,
    output logic       pkt_sent,
    output logic [7:0] seq_num
);

    localparam int BUF_BYTES = 4 * MAX_WORDS;
    localparam int CNT_W     = $clog2(BUF_BYTES + 1);
    localparam int IDX_W     = $clog2(BUF_BYTES);
    localparam int TMR_W     = (IDLE_TIMEOUT < 2) ? 1 : $clog2(IDLE_TIMEOUT);

    localparam logic [CNT_W-1:0] BUF_FULL = CNT_W'(BUF_BYTES);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(IDLE_TIMEOUT - 1);

    typedef enum logic [1:0] {
        COLLECT,
        HDR,
        PAYLOAD
    } state_t;

    state_t           state;
    logic [7:0]       buffer [BUF_BYTES];
    logic [CNT_W-1:0] byte_cnt;
    logic [CNT_W-1:0] out_idx;
    logic [7:0]       chk;
    logic [TMR_W-1:0] timer;
    logic [1:0]       hdr_idx;

    logic             pop;
    logic             handshake;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] next_idx;
    logic [7:0]       chk_next;
    logic [7:0]       word_cnt;
    logic [7:0]       next_byte;
    logic             flush_full;
    logic             flush_idle;
    logic             idle_eligible;

    // Pop is gated by rst_n so the strobe drops the moment reset asserts.
    always_comb begin
        pop           = rst_n && (state == COLLECT) && !s_fifo_empty && (byte_cnt < BUF_FULL);
        handshake     = m_axis_tvalid && m_axis_tready;
        cnt_next      = byte_cnt + CNT_W'(pop);
        chk_next      = pop ? (chk ^ s_fifo_dout) : chk;
        word_cnt      = 8'(byte_cnt >> 2);
        next_idx      = out_idx + CNT_W'(1);
        next_byte     = buffer[next_idx[IDX_W-1:0]];
        idle_eligible = !pop && (byte_cnt != '0) && (byte_cnt[1:0] == 2'b00);
        flush_full    = (cnt_next == BUF_FULL);
        flush_idle    = idle_eligible && (timer == TMR_LAST);
    end

    always_comb begin
        s_fifo_rd_en = pop;
    end

    always_ff @(posedge clk) begin
        if (pop) begin
            buffer[byte_cnt[IDX_W-1:0]] <= s_fifo_dout;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= COLLECT;
            byte_cnt      <= '0;
            out_idx       <= '0;
            chk           <= '0;
            timer         <= '0;
            hdr_idx       <= '0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            pkt_sent      <= 1'b0;
            seq_num       <= '0;
        end else begin
            pkt_sent <= 1'b0;
            unique case (state)
                COLLECT: begin
                    byte_cnt <= cnt_next;
                    chk      <= chk_next;
                    if (flush_full || flush_idle) begin
                        state         <= HDR;
                        timer         <= '0;
                        hdr_idx       <= '0;
                        m_axis_tvalid <= 1'b1;
                        m_axis_tdata  <= MAGIC;
                        m_axis_tlast  <= 1'b0;
                    end else if (idle_eligible) begin
                        timer <= timer + TMR_W'(1);
                    end else begin
                        timer <= '0;
                    end
                end

                HDR: begin
                    if (handshake) begin
                        hdr_idx <= hdr_idx + 2'd1;
                        case (hdr_idx)
                            2'd0:    m_axis_tdata <= seq_num;
                            2'd1:    m_axis_tdata <= word_cnt;
                            2'd2:    m_axis_tdata <= chk;
                            default: begin
                                // Payload is always at least one word, so byte 0 is never last.
                                state        <= PAYLOAD;
                                out_idx      <= '0;
                                m_axis_tdata <= buffer[0];
                                m_axis_tlast <= 1'b0;
                            end
                        endcase
                    end
                end

                PAYLOAD: begin
                    if (handshake) begin
                        if (m_axis_tlast) begin
                            state         <= COLLECT;
                            m_axis_tvalid <= 1'b0;
                            m_axis_tlast  <= 1'b0;
                            m_axis_tdata  <= '0;
                            pkt_sent      <= 1'b1;
                            seq_num       <= seq_num + 8'd1;
                            byte_cnt      <= '0;
                            chk           <= '0;
                            timer         <= '0;
                        end else begin
                            out_idx      <= next_idx;
                            m_axis_tdata <= next_byte;
                            m_axis_tlast <= ((next_idx + CNT_W'(1)) == byte_cnt);
                        end
                    end
                end

                default: state <= COLLECT;
            endcase
        end
    end

endmodule
